// File: rtl/uart_echo_ctrl_if.sv
// Ready/valid byte links between the UART receiver, the echo controller and the transmitter.
// master = echo controller side, slave = receiver/transmitter side.
interface uart_echo_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// UART echo sequencer: RX bytes -> FIFO -> mode-selected case transform -> TX ready/valid.
// Optional byte counters rx_bytes/tx_bytes are built only when ECHO_STATS_EN is defined.
module uart_echo_ctrl #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  uart_echo_ctrl_if.master bus,
  output logic [AW:0]   fifo_count,
  output logic          overflow
`ifdef ECHO_STATS_EN
  ,
  output logic [15:0]   rx_bytes,
  output logic [15:0]   tx_bytes
`endif
);

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e         state_q, state_d;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q;
  logic           rx_ready_q;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           push, push_ok, pop, full, handshake;

  function automatic logic [7:0] xform(input logic [7:0] c, input logic [1:0] m);
    logic is_lower;
    logic is_upper;
    is_lower = (c >= 8'h61) && (c <= 8'h7a);
    is_upper = (c >= 8'h41) && (c <= 8'h5a);
    xform = c;
    unique case (m)
      2'b01: begin
        if (is_lower) xform = c - 8'd32;
        else if (is_upper) xform = c + 8'd32;
      end
      2'b10: if (is_lower) xform = c - 8'd32;
      2'b11: if (is_upper) xform = c + 8'd32;
      default: xform = c;
    endcase
  endfunction

  assign full      = (count_q == Full);
  assign push      = bus.rx_valid & rx_ready_q;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign push_ok   = push & (~full | pop);
  assign handshake = (state_q == StSend) & bus.tx_ready;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StFetch;
      StFetch: begin
        pop       = 1'b1;
        tx_data_d = xform(mem[rd_ptr_q], mode);
        state_d   = StSend;
      end
      StSend:  if (bus.tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: only slots covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_valid = (state_q == StSend);
  assign bus.tx_data  = tx_data_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

`ifdef ECHO_STATS_EN
  logic [15:0] rx_bytes_q, tx_bytes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_bytes_q <= '0;
      tx_bytes_q <= '0;
    end else begin
      if (push_ok) rx_bytes_q <= rx_bytes_q + 16'd1;
      if (handshake) tx_bytes_q <= tx_bytes_q + 16'd1;
    end
  end

  assign rx_bytes = rx_bytes_q;
  assign tx_bytes = tx_bytes_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: vector table, directed corner sequences, random traffic.
module tb_uart_echo_ctrl;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  fifo_count;
  logic        overflow;
`ifdef ECHO_STATS_EN
  logic [15:0] rx_bytes, tx_bytes;
`endif

  uart_echo_ctrl_if bus ();

  uart_echo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow)
`ifdef ECHO_STATS_EN
    ,
    .rx_bytes   (rx_bytes),
    .tx_bytes   (tx_bytes)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0] m;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference transform stated as character-class arithmetic.
  function automatic logic [7:0] ref_xform(input logic [7:0] c, input logic [1:0] m);
    bit lower = c inside {[8'h61:8'h7a]};
    bit upper = c inside {[8'h41:8'h5a]};
    bit to_up = lower && (m == 2'd1 || m == 2'd2);
    bit to_lo = upper && (m == 2'd1 || m == 2'd3);
    return to_up ? c - 8'd32 : (to_lo ? c + 8'd32 : c);
  endfunction

  task automatic drain(input string name);
    int waited;
    bus.tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (!bus.tx_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.tx_valid) begin
        check({name, " timeout"}, bus.tx_valid, 1);
        exp_q.delete();
      end else begin
        check({name, " data"}, bus.tx_data, exp_q.pop_front());
        @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    check({name, " idle"}, bus.tx_valid, 0);
    check({name, " count"}, fifo_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    mode = 2'b00;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_ready = 1'b0;

    tbl[0]  = '{2'd0, 8'h61, 8'h61};  tbl[1]  = '{2'd0, 8'h5A, 8'h5A};
    tbl[2]  = '{2'd0, 8'h31, 8'h31};  tbl[3]  = '{2'd1, 8'h61, 8'h41};
    tbl[4]  = '{2'd1, 8'h5A, 8'h7A};  tbl[5]  = '{2'd1, 8'h31, 8'h31};
    tbl[6]  = '{2'd2, 8'h61, 8'h41};  tbl[7]  = '{2'd2, 8'h5A, 8'h5A};
    tbl[8]  = '{2'd2, 8'h31, 8'h31};  tbl[9]  = '{2'd3, 8'h61, 8'h61};
    tbl[10] = '{2'd3, 8'h5A, 8'h7A};  tbl[11] = '{2'd3, 8'h31, 8'h31};
    tbl[12] = '{2'd1, 8'h40, 8'h40};  tbl[13] = '{2'd2, 8'h7B, 8'h7B};
    tbl[14] = '{2'd3, 8'h60, 8'h60};  tbl[15] = '{2'd2, 8'h7A, 8'h5A};

    // Reset state
    #1;
    check("rst rx_ready", bus.rx_ready, 0);
    check("rst tx_valid", bus.tx_valid, 0);
    check("rst tx_data", bus.tx_data, 8'h00);
    check("rst count", fifo_count, 0);
    check("rst overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rx_ready before edge", bus.rx_ready, 0);
    @(negedge clk);
    check("rx_ready after release", bus.rx_ready, 1);

    // Single byte latency, mode 01
    mode = 2'd1;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h41;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("lat count after push", fifo_count, 1);
    check("lat valid N", bus.tx_valid, 0);
    @(negedge clk);
    check("lat valid N+1", bus.tx_valid, 0);
    @(negedge clk);
    check("lat valid N+2", bus.tx_valid, 1);
    check("lat data", bus.tx_data, 8'h61);
    @(negedge clk);
    check("lat valid after hs", bus.tx_valid, 0);
    check("lat count end", fifo_count, 0);

    // Vector table
    foreach (tbl[i]) begin
      mode = tbl[i].m;
      bus.rx_valid = 1'b1;
      bus.rx_data = tbl[i].din;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      waited = 0;
      while (!bus.tx_valid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("xform m%0d %02h", tbl[i].m, tbl[i].din), bus.tx_data, tbl[i].dout);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Mode change during SEND leaves the in-flight byte alone
    mode = 2'd1;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h61;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    mode = 2'd0;
    repeat (2) @(negedge clk);
    check("inflight valid held", bus.tx_valid, 1);
    check("inflight data", bus.tx_data, 8'h41);
    drain("inflight");

    // Backpressure and overflow
    mode = 2'd0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    check("ovf count", fifo_count, DEPTH);
    check("ovf flag", overflow, 1);
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(8'h41 + 8'(i));
    drain("ovf drain");
    check("ovf sticky", overflow, 1);

    // Asynchronous reset mid-SEND
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h70 + 8'(i);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("pre-rst valid", bus.tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst tx_valid", bus.tx_valid, 0);
    check("async rst count", fifo_count, 0);
    check("async rst overflow", overflow, 0);
    check("async rst tx_data", bus.tx_data, 0);
    check("async rst rx_ready", bus.rx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready after rst2", bus.rx_ready, 1);

    // Full FIFO with coincident pop and push
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("full count", fifo_count, DEPTH);
    check("full head", bus.tx_data, 8'h30);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h55;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("simul count", fifo_count, DEPTH);
    check("simul overflow", overflow, 0);
    for (int i = 1; i < DEPTH + 1; i++) exp_q.push_back(8'h30 + 8'(i));
    exp_q.push_back(8'h55);
    drain("simul drain");
    check("simul overflow end", overflow, 0);

    // Random traffic against the queue model
    do_reset();
    begin
      int outstanding = 0;
      int rx_cnt = 0;
      int tx_cnt = 0;
      bit prev_valid = 0;
      bit prev_hs = 0;
      logic [7:0] prev_data = 8'h00;
      logic [7:0] b;
      for (int seg = 0; seg < 4; seg++) begin
        mode = 2'(seg);
        for (int cyc = 0; cyc < 400; cyc++) begin
          @(negedge clk);
          bus.rx_valid = 1'b0;
          check("rand occupancy", (fifo_count <= outstanding) && (outstanding - fifo_count <= 1), 1);
          if (prev_valid && !prev_hs) begin
            check("rand valid held", bus.tx_valid, 1);
            check("rand data stable", bus.tx_data, prev_data);
          end
          bus.tx_ready = ($urandom_range(0, 3) != 0);
          prev_valid = bus.tx_valid;
          prev_data = bus.tx_data;
          prev_hs = bus.tx_valid && bus.tx_ready;
          if (prev_hs) begin
            if (exp_q.size() == 0) check("rand unexpected byte", bus.tx_data, 32'hFFFF_FFFF);
            else check("rand data", bus.tx_data, exp_q.pop_front());
            outstanding--;
            tx_cnt++;
          end
          if (outstanding < DEPTH && $urandom_range(0, 4) == 0) begin
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h40, 8'h7f)) : 8'($urandom);
            bus.rx_valid = 1'b1;
            bus.rx_data = b;
            exp_q.push_back(ref_xform(b, mode));
            outstanding++;
            rx_cnt++;
          end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        tx_cnt += exp_q.size();
        drain("rand drain");
        prev_valid = 0;
        prev_hs = 0;
        outstanding = 0;
      end
      check("rand overflow", overflow, 0);
`ifdef ECHO_STATS_EN
      check("stats rx_bytes", rx_bytes, 16'(rx_cnt));
      check("stats tx_bytes", tx_bytes, 16'(tx_cnt));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
